router_top: RTL and testbench
=============================

Name: router_top

Overview:
- Single-input, three-output (1x3) byte packet router.
- Accepts packets on an 8-bit input bus, checks parity, and buffers each packet in the output FIFO selected by the header address.
- Three downstream readers drain the FIFOs independently.
- Contains an input FSM, a parity/error register, three FIFOs and per-port read-timeout logic.

Parameters:
- DEPTH, 64, entries per output FIFO; must be a power of 2 and at least 64, so a maximum packet of header plus 63 payload bytes fits.
- TIMEOUT, 30, consecutive cycles with vld_out[i]=1 and rd_en[i]=0 before FIFO i is flushed.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pkt_valid  in  1  high for the header and payload bytes; low on the parity byte.
- rd_en  in  3  per-port read enable.
- data_in  in  8  packet byte stream.
- vld_out  out  3  vld_out[i] = FIFO i not empty.
- errr  out  1  parity error flag.
- busy  out  1  source must hold data_in while high.
- data_out_0, data_out_1, data_out_2  out  8 each  read data of FIFO 0/1/2.

Behaviour:
- Packet format: header = {len[5:0], addr[1:0]}, then len payload bytes, then 1 parity byte. The parity byte equals the XOR of the header and all payload bytes.
- Reset, asynchronous: FSM to DECODE; FIFOs empty; all pointers, counters and timeout counters cleared. Outputs: busy=0, errr=0, vld_out=000, data_out_*=00.
- FSM states: DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, CHECK_PARITY, DROP. busy is decoded from state plus FIFO-full and must be valid before the next falling edge.
- DECODE (busy=0): on a posedge with pkt_valid=1, latch data_in as header and compute internal parity = header.
  - addr=3: go to DROP.
  - FIFO[addr] not empty: go to WAIT_EMPTY.
  - Otherwise: go to LOAD_FIRST.
- WAIT_EMPTY (busy=1): stay until FIFO[addr] is empty, then go to LOAD_FIRST. data_in is ignored.
- LOAD_FIRST (busy=1, one cycle): write the latched header into FIFO[addr], go to LOAD_DATA. The header byte still on data_in is ignored.
- LOAD_DATA:
  - busy = FIFO[addr] full.
  - If full: no write, hold state.
  - Else if pkt_valid=1: write data_in and XOR it into the internal parity.
  - Else (pkt_valid=0): data_in is the parity byte; compare it with the internal parity, set errr=1 on mismatch, go to CHECK_PARITY. The parity byte is not stored.
- CHECK_PARITY (busy=1, one cycle): go to DECODE.
- DROP (busy=0): discard bytes until pkt_valid=0 is sampled, then go to DECODE. errr is unchanged.
- errr: registered. Asserts the cycle after a bad parity byte is sampled. Holds until the next header is latched in DECODE or until reset.
- Payload byte count is not checked against len; the end of packet is defined solely by pkt_valid falling.
- FIFO i:
  - Synchronous write from the FSM.
  - Read on posedge when rd_en[i]=1 and not empty: data_out_i <= head entry, pointer advances.
  - Read while empty is ignored, and data_out_i holds its last value.
  - Simultaneous read and write are both performed; full/empty use count tracking; pointers wrap modulo DEPTH.
- Read timeout: counter i increments each cycle while vld_out[i]=1 and rd_en[i]=0, and clears otherwise. On reaching TIMEOUT, FIFO i is flushed (pointers and count to 0). If the FSM is loading FIFO i at that time, the FSM returns to DECODE and the rest of that packet is discarded as in DROP.
- vld_out[i] updates on the same edge as the FIFO count.

Test Plan:
- Reset with rst=1, then release -> busy=0, errr=0, vld_out=000, data_out_*=00.
- Send header 0x20 (len 8, addr 0) + 8 random bytes + correct parity, then rd_en=001 -> busy high for exactly one cycle after the header. vld_out[0]=1 after the header write. data_out_0 yields 0x20 then the 8 payload bytes in order. vld_out[0] falls after the 9th read; errr=0.
- Send header 0x39 (len 14, addr 1) and header 0x46 (len 17, addr 2), each with payload and correct parity, each read via rd_en[1]/rd_en[2] -> correct byte order on the matching port, other ports stay invalid, errr=0.
- Packet to addr 0 with a wrong parity byte -> errr=1 one cycle after the parity byte, cleared when the next header is accepted.
- Packet to port 1 left unread for 30 cycles -> FIFO 1 flushed, vld_out[1]=0.
- Header to a non-empty FIFO -> busy=1 in WAIT_EMPTY until rd_en drains it. Header with addr=3 -> nothing stored, vld_out unchanged, busy=0.

Source files
------------

// File: rtl/router_top.sv
// -----------------------------------------------------------------------------
// router_top: 1x3 byte packet router.
//
// An input FSM accepts packets of the form {len[5:0], addr[1:0]}, len payload
// bytes, parity byte. It checks the parity and buffers header and payload in
// one of three output FIFOs, selected by addr. Each FIFO is drained
// independently by its own reader. If a reader leaves a non-empty FIFO unread
// for TIMEOUT consecutive cycles, that FIFO is flushed.
//
// Ports:
//   clk                    single clock, rising edge
//   rst                    asynchronous, active-high reset
//   pkt_valid              high for header and payload bytes, low on the parity byte
//   rd_en[2:0]             per-port read enable
//   data_in[7:0]           packet byte stream
//   vld_out[2:0]           FIFO i not empty
//   errr                   parity error flag (registered)
//   busy                   source must hold data_in while high
//   data_out_0/1/2[7:0]    read data of FIFO 0/1/2
// -----------------------------------------------------------------------------
module router_top #(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [2:0] rd_en,
  input  logic [7:0] data_in,
  output logic [2:0] vld_out,
  output logic       errr,
  output logic       busy,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    DECODE,
    WAIT_EMPTY,
    LOAD_FIRST,
    LOAD_DATA,
    CHECK_PARITY,
    DROP
  } state_t;

  state_t state, state_nxt;

  logic [7:0] header;
  logic [7:0] par_acc;
  logic [1:0] addr;
  logic [2:0] port_sel;

  logic [2:0] empty_vec;
  logic [2:0] full_vec;
  logic [2:0] flush_vec;
  logic [2:0] wr_en;
  logic [7:0] wr_data;
  logic [2:0][7:0] rd_data;

  assign addr     = header[1:0];
  assign port_sel = 3'b001 << addr;  // addr=3 selects no port
  assign vld_out  = ~empty_vec;

  assign data_out_0 = rd_data[0];
  assign data_out_1 = rd_data[1];
  assign data_out_2 = rd_data[2];

  // ---------------------------------------------------------------------------
  // Input FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DECODE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Input FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt
    // unassigned and no latch is inferred.
    state_nxt = state;
    unique case (state)
      DECODE: begin
        if (pkt_valid) begin
          // Header is still on data_in; the latched copy is not visible yet.
          if (data_in[1:0] == 2'd3)            state_nxt = DROP;
          else if (!empty_vec[data_in[1:0]])   state_nxt = WAIT_EMPTY;
          else                                 state_nxt = LOAD_FIRST;
        end
      end
      WAIT_EMPTY: begin
        if (empty_vec[addr]) state_nxt = LOAD_FIRST;
      end
      LOAD_FIRST: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        // A timeout flush of the target FIFO abandons the packet; the
        // remaining bytes are swallowed in DROP unless this was its last byte.
        if (flush_vec[addr])                   state_nxt = pkt_valid ? DROP : DECODE;
        else if (!full_vec[addr] && !pkt_valid) state_nxt = CHECK_PARITY;
      end
      CHECK_PARITY: state_nxt = DECODE;
      DROP: begin
        if (!pkt_valid) state_nxt = DECODE;
      end
      default: state_nxt = DECODE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Input FSM: outputs (busy and FIFO write strobes)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = 1'b0;
    wr_en   = 3'b000;
    wr_data = data_in;
    unique case (state)
      WAIT_EMPTY, CHECK_PARITY: busy = 1'b1;
      LOAD_FIRST: begin
        busy    = 1'b1;
        wr_en   = port_sel;
        wr_data = header;
      end
      LOAD_DATA: begin
        busy = full_vec[addr];
        if (!full_vec[addr] && pkt_valid) wr_en = port_sel;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Header latch, running parity and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      header  <= 8'h00;
      par_acc <= 8'h00;
      errr    <= 1'b0;
    end else begin
      unique case (state)
        DECODE: begin
          if (pkt_valid) begin
            header  <= data_in;
            par_acc <= data_in;
            errr    <= 1'b0;
          end
        end
        LOAD_DATA: begin
          if (!full_vec[addr] && !flush_vec[addr]) begin
            if (pkt_valid)                 par_acc <= par_acc ^ data_in;
            else if (data_in != par_acc)   errr    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFOs with per-port read timeout
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    dout;
    logic          do_wr;
    logic          do_rd;

    assign empty_vec[g] = (count == '0);
    assign full_vec[g]  = (count == CW'(DEPTH));
    assign do_wr        = wr_en[g] && !full_vec[g] && !flush_vec[g];
    assign do_rd        = rd_en[g] && !empty_vec[g];
    // Flush on the edge that would complete TIMEOUT idle cycles.
    assign flush_vec[g] = !empty_vec[g] && !rd_en[g] &&
                          (idle_cnt == TW'(TIMEOUT - 1));
    assign rd_data[g]   = dout;

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count alone, which keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        dout   <= 8'h00;
      end else if (flush_vec[g]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + AW'(1);
        if (do_rd) begin
          rd_ptr <= rd_ptr + AW'(1);
          dout   <= mem[rd_ptr];
        end
        unique case ({do_wr, do_rd})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   idle_cnt <= '0;
      else if (flush_vec[g])                     idle_cnt <= '0;
      else if (!empty_vec[g] && !rd_en[g])       idle_cnt <= idle_cnt + TW'(1);
      else                                       idle_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_router_top.sv
// -----------------------------------------------------------------------------
// tb_router_top: self-checking bench for router_top.
// A table of packet vectors is sent, read back and compared byte by byte,
// followed by hand-written sequences for WAIT_EMPTY, addr=3 drop, read
// timeout and a maximum-length packet streamed through a wrapping FIFO.
// -----------------------------------------------------------------------------
module tb_router_top;

  logic       clk;
  logic       rst;
  logic       pkt_valid;
  logic [2:0] rd_en;
  logic [7:0] data_in;
  logic [2:0] vld_out;
  logic       errr;
  logic       busy;
  logic [7:0] data_out_0, data_out_1, data_out_2;

  router_top #(.DEPTH(64), .TIMEOUT(30)) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .rd_en      (rd_en),
    .data_in    (data_in),
    .vld_out    (vld_out),
    .errr       (errr),
    .busy       (busy),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_b [64];
  logic [7:0] par_b;

  typedef struct {
    logic [7:0] hdr;
    logic       bad;
    logic       exp_err;
    logic [2:0] exp_vld;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dout(input int p);
    case (p)
      0:       return data_out_0;
      1:       return data_out_1;
      default: return data_out_2;
    endcase
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  // Build header + payload bytes and the matching parity byte.
  task automatic fill_pkt(input logic [7:0] hdr);
    int len;
    len = int'(hdr[7:2]);
    exp_b[0] = hdr;
    par_b = hdr;
    for (int k = 1; k <= len; k++) begin
      exp_b[k] = 8'(int'(hdr) + k * 29 + 5);
      par_b = par_b ^ exp_b[k];
    end
  endtask

  task automatic send_hdr(input logic [7:0] hdr, output int nb);
    int dummy;
    wait_ready(dummy);
    pkt_valid = 1'b1;
    data_in   = hdr;
    tick();
    wait_ready(nb);
  endtask

  task automatic send_body(input int len, input logic bad);
    int dummy;
    for (int k = 1; k <= len; k++) begin
      wait_ready(dummy);
      pkt_valid = 1'b1;
      data_in   = exp_b[k];
      tick();
    end
    wait_ready(dummy);
    check("err_pre_parity", 32'(errr), 32'd0);
    pkt_valid = 1'b0;
    data_in   = bad ? (par_b ^ 8'hFF) : par_b;
    tick();
  endtask

  task automatic read_check(input int p, input int len);
    rd_en = 3'(1 << p);
    for (int k = 0; k <= len; k++) begin
      tick();
      check($sformatf("rd_data_p%0d_b%0d", p, k), 32'(dout(p)), 32'(exp_b[k]));
      check($sformatf("rd_vld_p%0d_b%0d", p, k), 32'(vld_out[p]), 32'(k < len));
    end
    tick();
    check($sformatf("rd_hold_p%0d", p), 32'(dout(p)), 32'(exp_b[len]));
    rd_en = 3'b000;
  endtask

  task automatic read_stream(input int nbytes);
    int   idx;
    int   guard;
    logic was;
    idx   = 0;
    guard = 0;
    rd_en = 3'b001;
    while (idx < nbytes && guard < 300) begin
      was = vld_out[0];
      tick();
      if (was) begin
        check($sformatf("wrap_data_b%0d", idx), 32'(data_out_0), 32'(exp_b[idx]));
        idx++;
      end
      guard++;
    end
    check("wrap_count", 32'(idx), 32'(nbytes));
    rd_en = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int port;
    int len;
    int drained;

    //            hdr    bad   err   vld
    vecs[0] = '{8'h20, 1'b0, 1'b0, 3'b001};  // len 8,  addr 0
    vecs[1] = '{8'h39, 1'b0, 1'b0, 3'b010};  // len 14, addr 1
    vecs[2] = '{8'h46, 1'b0, 1'b0, 3'b100};  // len 17, addr 2
    vecs[3] = '{8'h0C, 1'b1, 1'b1, 3'b001};  // len 3,  addr 0, bad parity
    vecs[4] = '{8'h12, 1'b0, 1'b0, 3'b100};  // len 4,  addr 2, clears errr

    rst       = 1'b1;
    pkt_valid = 1'b0;
    rd_en     = 3'b000;
    data_in   = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errr", 32'(errr), 32'd0);
    check("rst_vld",  32'(vld_out), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_vld",  32'(vld_out), 32'd0);
    check("post_rst_d0",   32'(data_out_0), 32'd0);
    check("post_rst_d1",   32'(data_out_1), 32'd0);
    check("post_rst_d2",   32'(data_out_2), 32'd0);

    // Table-driven packets
    for (int i = 0; i < 5; i++) begin
      port = int'(vecs[i].hdr[1:0]);
      len  = int'(vecs[i].hdr[7:2]);
      fill_pkt(vecs[i].hdr);
      send_hdr(vecs[i].hdr, nb);
      check($sformatf("v%0d_hdr_busy_cycles", i), 32'(nb), 32'd1);
      check($sformatf("v%0d_err_cleared", i), 32'(errr), 32'd0);
      check($sformatf("v%0d_vld_after_hdr", i), 32'(vld_out), 32'(vecs[i].exp_vld));
      send_body(len, vecs[i].bad);
      check($sformatf("v%0d_errr", i), 32'(errr), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_vld", i), 32'(vld_out), 32'(vecs[i].exp_vld));
      read_check(port, len);
      check($sformatf("v%0d_vld_drained", i), 32'(vld_out), 32'd0);
      check($sformatf("v%0d_errr_hold", i), 32'(errr), 32'(vecs[i].exp_err));
    end

    // Header to a non-empty FIFO waits in WAIT_EMPTY until drained
    fill_pkt(8'h11);                       // len 4, addr 1
    send_hdr(8'h11, nb);
    send_body(4, 1'b0);
    wait_ready(nb);
    pkt_valid = 1'b1;
    data_in   = 8'h09;                     // len 2, addr 1
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wait_busy_%0d", k), 32'(busy), 32'd1);
      tick();
    end
    rd_en   = 3'b010;
    drained = 0;
    while (vld_out[1] && drained < 20) begin
      tick();
      drained++;
      check($sformatf("drain_busy_%0d", drained), 32'(busy), 32'd1);
    end
    rd_en = 3'b000;
    check("drain_count", 32'(drained), 32'd5);
    wait_ready(nb);
    check("wait_release_cycles", 32'(nb), 32'd2);
    check("wait_vld_hdr", 32'(vld_out), 32'b010);
    fill_pkt(8'h09);
    send_body(2, 1'b0);
    check("wait_pkt_errr", 32'(errr), 32'd0);
    read_check(1, 2);

    // addr=3 is dropped; a pending packet on port 2 is left untouched
    fill_pkt(8'h12);
    send_hdr(8'h12, nb);
    send_body(4, 1'b0);
    send_hdr(8'h0B, nb);                   // len 2, addr 3
    check("drop_busy_hdr", 32'(nb), 32'd0);
    for (int k = 0; k < 2; k++) begin
      data_in = 8'hA0 + 8'(k);
      tick();
      check($sformatf("drop_busy_%0d", k), 32'(busy), 32'd0);
      check($sformatf("drop_vld_%0d", k), 32'(vld_out), 32'b100);
    end
    pkt_valid = 1'b0;
    data_in   = 8'h55;
    tick();
    check("drop_end_vld",  32'(vld_out), 32'b100);
    check("drop_end_busy", 32'(busy), 32'd0);
    read_check(2, 4);

    // Read timeout flushes an unread FIFO
    fill_pkt(8'h09);
    send_hdr(8'h09, nb);
    send_body(2, 1'b0);
    repeat (25) tick();
    check("timeout_before", 32'(vld_out), 32'b010);
    repeat (3) tick();
    check("timeout_after", 32'(vld_out), 32'b000);
    check("timeout_busy", 32'(busy), 32'd0);

    // Maximum packet streamed through port 0 while reading; pointers wrap
    fill_pkt(8'hFC);                       // len 63, addr 0
    fork
      begin
        send_hdr(8'hFC, nb);
        send_body(63, 1'b0);
      end
      read_stream(64);
    join
    check("max_errr", 32'(errr), 32'd0);
    check("max_vld",  32'(vld_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
